// File: rtl/onedconv_feed_ctrl.sv
// onedconv_feed_ctrl: BRAM address / shift-enable sequencer for the 1-D conv input buffers.
// Ports: clk, rst (sync, active-low), start + captured tile params in; weight/ifmap BRAM
// addr/rd_en, per-row shift enables, zero/data selects, busy, done out.
// Optional ONEDCONV_FEED_PERF_EN adds tile_count and pad_count.
module onedconv_feed_ctrl #(
  parameter int DW        = 16,
  parameter int Dimension = 16,
  parameter int AW        = 10,
  parameter int STRIDE    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        weight_base,
  input  logic [AW-1:0]        ifmap_base,
  input  logic [AW-1:0]        ifmap_len,
  input  logic [7:0]           pad_left,
  input  logic [AW-1:0]        tile_start,
  output logic [AW-1:0]        weight_addr,
  output logic                 weight_rd_en,
  output logic [AW-1:0]        ifmap_addr,
  output logic                 ifmap_rd_en,
  output logic [Dimension-1:0] en_shift_reg_weight_muxed,
  output logic [Dimension-1:0] en_shift_reg_ifmap_muxed,
  output logic                 zero_or_data_weight,
  output logic                 zero_or_data,
  output logic                 busy,
  output logic                 done
`ifdef ONEDCONV_FEED_PERF_EN
  ,
  output logic [31:0]          tile_count,
  output logic [31:0]          pad_count
`endif
);

  localparam int DEPTH = Dimension + 1;
  localparam int N     = (Dimension - 1) * STRIDE + DEPTH;
  localparam int CW    = $clog2(N + 1);
  localparam int VW    = AW + 9;

  if (DW < 1 || Dimension < 1 || STRIDE < 1) begin : g_bad_param
    $error("onedconv_feed_ctrl: bad parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_ILOAD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          w_cap;

  logic [AW-1:0] r_weight_base;
  logic [AW-1:0] r_ifmap_base;
  logic [AW-1:0] r_ifmap_len;
  logic [7:0]    r_pad_left;
  logic [AW-1:0] r_tile_start;

  logic [VW-1:0] w_v, w_lo, w_hi;
  logic          w_ok, w_wl, w_il, w_j0;

  logic          r_a_w, r_a_wd, r_a_i, r_a_ok;
  logic [CW-1:0] r_a_k;
  logic [Dimension-1:0] w_rows;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cap      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_WLOAD;
          w_cnt_nx   = '0;
          w_cap      = 1'b1;
        end
      end
      S_WLOAD: begin
        if (r_cnt == CW'(DEPTH - 1)) begin
          w_state_nx = S_ILOAD;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_ILOAD: begin
        if (r_cnt == CW'(N - 1)) begin
          w_state_nx = S_FLUSH;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_FLUSH: w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_weight_base <= '0;
      r_ifmap_base  <= '0;
      r_ifmap_len   <= '0;
      r_pad_left    <= '0;
      r_tile_start  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_cap) begin
        r_weight_base <= weight_base;
        r_ifmap_base  <= ifmap_base;
        r_ifmap_len   <= ifmap_len;
        r_pad_left    <= pad_left;
        r_tile_start  <= tile_start;
      end
    end
  end

  // Padding test is done wide so tile_start + k never wraps.
  assign w_v  = VW'(r_tile_start) + VW'(r_cnt);
  assign w_lo = VW'(r_pad_left);
  assign w_hi = w_lo + VW'(r_ifmap_len);
  assign w_ok = (w_v >= w_lo) && (w_v < w_hi);
  assign w_wl = (r_state == S_WLOAD);
  assign w_il = (r_state == S_ILOAD);
  assign w_j0 = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      weight_addr  <= '0;
      weight_rd_en <= 1'b0;
      ifmap_addr   <= '0;
      ifmap_rd_en  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      r_a_w        <= 1'b0;
      r_a_wd       <= 1'b0;
      r_a_i        <= 1'b0;
      r_a_ok       <= 1'b0;
      r_a_k        <= '0;
    end else begin
      weight_rd_en <= w_wl & ~w_j0;
      weight_addr  <= (w_wl & ~w_j0) ?
                      r_weight_base + AW'(r_cnt) - AW'(1) : '0;
      ifmap_rd_en  <= w_il & w_ok;
      if (!w_il)
        ifmap_addr <= '0;
      else if (w_ok)
        ifmap_addr <= r_ifmap_base + AW'(w_v) - AW'(r_pad_left);
      else
        ifmap_addr <= r_ifmap_base;
      busy   <= w_wl | w_il | (r_state == S_FLUSH);
      done   <= (r_state == S_DONE);
      r_a_w  <= w_wl;
      r_a_wd <= ~w_j0;
      r_a_i  <= w_il;
      r_a_ok <= w_ok;
      r_a_k  <= r_cnt;
    end
  end

  // Row i sees ifmap words k in [i*STRIDE, i*STRIDE+DEPTH).
  always_comb begin
    w_rows = '0;
    for (int i = 0; i < Dimension; i++) begin
      w_rows[i] = (32'(r_a_k) >= 32'(i * STRIDE)) &&
                  (32'(r_a_k) <  32'(i * STRIDE + DEPTH));
    end
  end

  // Controls trail addresses by one cycle to match BRAM read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_shift_reg_weight_muxed <= '0;
      en_shift_reg_ifmap_muxed  <= '0;
      zero_or_data_weight       <= 1'b0;
      zero_or_data              <= 1'b0;
    end else begin
      en_shift_reg_weight_muxed <= {Dimension{r_a_w}};
      zero_or_data_weight       <= r_a_w & r_a_wd;
      en_shift_reg_ifmap_muxed  <= r_a_i ? w_rows : '0;
      zero_or_data              <= r_a_i & r_a_ok;
    end
  end

`ifdef ONEDCONV_FEED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tile_count <= '0;
      pad_count  <= '0;
    end else begin
      if (r_state == S_DONE && tile_count != '1)
        tile_count <= tile_count + 1'b1;
      if (r_a_i && !r_a_ok && pad_count != '1)
        pad_count <= pad_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_onedconv_feed_ctrl.sv
// tb_onedconv_feed_ctrl: randomized + directed bench for onedconv_feed_ctrl.
// Timeline model computes every output from cycles-since-accept and captured params.
module tb_onedconv_feed_ctrl;

  localparam int DIM = 4;
  localparam int AW  = 10;
  localparam int DEP = DIM + 1;
  localparam int NN  = (DIM - 1) + DEP;
  localparam int TL  = DEP + NN + 2;

  logic           clk;
  logic           rst;
  logic           start;
  logic [AW-1:0]  weight_base, ifmap_base, ifmap_len, tile_start;
  logic [7:0]     pad_left;
  logic [AW-1:0]  weight_addr, ifmap_addr;
  logic           weight_rd_en, ifmap_rd_en;
  logic [DIM-1:0] en_w, en_i;
  logic           zodw, zod, busy, done;
`ifdef ONEDCONV_FEED_PERF_EN
  logic [31:0]    tile_count, pad_count;
`endif

  onedconv_feed_ctrl #(
    .DW(16), .Dimension(DIM), .AW(AW), .STRIDE(1)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .weight_base               (weight_base),
    .ifmap_base                (ifmap_base),
    .ifmap_len                 (ifmap_len),
    .pad_left                  (pad_left),
    .tile_start                (tile_start),
    .weight_addr               (weight_addr),
    .weight_rd_en              (weight_rd_en),
    .ifmap_addr                (ifmap_addr),
    .ifmap_rd_en               (ifmap_rd_en),
    .en_shift_reg_weight_muxed (en_w),
    .en_shift_reg_ifmap_muxed  (en_i),
    .zero_or_data_weight       (zodw),
    .zero_or_data              (zod),
    .busy                      (busy),
    .done                      (done)
`ifdef ONEDCONV_FEED_PERF_EN
    ,
    .tile_count                (tile_count),
    .pad_count                 (pad_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int tc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  bit m_act = 0;
  bit seen  = 0;
  int m_c   = 0;
  int m_wb, m_ib, m_len, m_pl, m_ts;

  function automatic bit valid_k(int k);
    int v;
    v = m_ts + k;
    return (v >= m_pl) && (v < m_pl + m_len);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_act = 0;
      m_c   = 0;
      seen  = 1;
    end else if (m_act && m_c < TL) begin
      m_c = m_c + 1;
    end else if (start) begin
      m_act = 1;
      m_c   = 0;
      m_wb  = int'(weight_base);
      m_ib  = int'(ifmap_base);
      m_len = int'(ifmap_len);
      m_pl  = int'(pad_left);
      m_ts  = int'(tile_start);
    end else begin
      m_act = 0;
    end
  end

  always @(negedge clk) begin
    int c, k;
    bit a, e_wrd, e_ird, e_is, e_we, e_zw, e_ie, e_z;
    logic [DIM-1:0] e_rows;
    if (seen) begin
      c = m_c;
      a = m_act;
      e_wrd = a && c >= 2 && c <= DEP;
      e_is  = a && c >= DEP + 1 && c <= DEP + NN;
      e_ird = e_is && valid_k(c - DEP - 1);
      e_we  = a && c >= 2 && c <= DEP + 1;
      e_zw  = a && c >= 3 && c <= DEP + 1;
      e_ie  = a && c >= DEP + 2 && c <= DEP + NN + 1;
      k     = c - DEP - 2;
      e_z   = e_ie && valid_k(k);
      e_rows = '0;
      for (int i = 0; i < DIM; i++)
        e_rows[i] = e_ie && k >= i && k < i + DEP;
      chk("busy", 32'(busy), 32'(a && c >= 1 && c <= DEP + NN + 1));
      chk("done", 32'(done), 32'(a && c == TL));
      chk("weight_rd_en", 32'(weight_rd_en), 32'(e_wrd));
      if (e_wrd)
        chk("weight_addr", 32'(weight_addr), 32'((m_wb + c - 2) & 1023));
      chk("ifmap_rd_en", 32'(ifmap_rd_en), 32'(e_ird));
      if (e_is)
        chk("ifmap_addr", 32'(ifmap_addr),
            e_ird ? 32'((m_ib + m_ts + c - DEP - 1 - m_pl) & 1023)
                  : 32'(m_ib));
      chk("en_weight", 32'(en_w), e_we ? 32'((1 << DIM) - 1) : 32'd0);
      chk("zero_or_data_weight", 32'(zodw), 32'(e_zw));
      chk("en_ifmap", 32'(en_i), 32'(e_rows));
      chk("zero_or_data", 32'(zod), 32'(e_z));
    end
  end

  task automatic at(input int c);
    repeat (c - tc) @(posedge clk);
    tc = c;
    #2;
  endtask

  task automatic tile(input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                      input logic [AW-1:0] len, input logic [7:0] pl,
                      input logic [AW-1:0] ts, input bit hold);
    weight_base = wb;
    ifmap_base  = ib;
    ifmap_len   = len;
    pad_left    = pl;
    tile_start  = ts;
    start       = 1'b1;
    @(posedge clk);
    tc = 0;
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic rnd_params();
    weight_base = AW'($urandom);
    ifmap_base  = AW'($urandom);
    if ($urandom % 4 == 0) begin
      ifmap_len  = AW'($urandom);
      pad_left   = 8'($urandom);
      tile_start = AW'($urandom);
    end else begin
      ifmap_len  = AW'($urandom_range(0, 12));
      pad_left   = 8'($urandom_range(0, 10));
      tile_start = AW'($urandom_range(0, 20));
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    weight_base = '0;
    ifmap_base = '0;
    ifmap_len = '0;
    pad_left = '0;
    tile_start = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle weight_addr", 32'(weight_addr), 32'd0);
    chk("idle ifmap_addr", 32'(ifmap_addr), 32'd0);
    chk("idle en_ifmap", 32'(en_i), 32'd0);

    tile(10'h10, 10'h40, 10'd20, 8'd0, 10'd0, 1'b0);
    at(1);  chk("s2 c1 wrd", 32'(weight_rd_en), 32'd0);
    chk("s2 c1 busy", 32'(busy), 32'd1);
    at(2);  chk("s2 c2 waddr", 32'(weight_addr), 32'h10);
    chk("s2 c2 zodw", 32'(zodw), 32'd0);
    chk("s2 c2 en_w", 32'(en_w), 32'hF);
    at(3);  chk("s2 c3 zodw", 32'(zodw), 32'd1);
    at(5);  chk("s2 c5 waddr", 32'(weight_addr), 32'h13);
    at(6);  chk("s2 c6 iaddr", 32'(ifmap_addr), 32'h40);
    at(7);  chk("s3 c7 en_i", 32'(en_i), 32'b0001);
    at(10); chk("s3 c10 en_i", 32'(en_i), 32'b1111);
    at(12); chk("s3 c12 en_i", 32'(en_i), 32'b1110);
    at(13); chk("s2 c13 iaddr", 32'(ifmap_addr), 32'h47);
    at(14); chk("s3 c14 en_i", 32'(en_i), 32'b1000);
    at(15); chk("s2 c15 done", 32'(done), 32'd1);
    chk("s2 c15 busy", 32'(busy), 32'd0);
    at(16); chk("s2 c16 done", 32'(done), 32'd0);

    tile(10'h0, 10'h40, 10'd3, 8'd2, 10'd0, 1'b0);
    at(6);  chk("s4 c6 ird", 32'(ifmap_rd_en), 32'd0);
    chk("s4 c6 iaddr", 32'(ifmap_addr), 32'h40);
    at(7);  chk("s4 c7 zod", 32'(zod), 32'd0);
    at(8);  chk("s4 c8 iaddr", 32'(ifmap_addr), 32'h40);
    at(9);  chk("s4 c9 zod", 32'(zod), 32'd1);
    at(10); chk("s4 c10 iaddr", 32'(ifmap_addr), 32'h42);
    at(11); chk("s4 c11 zod", 32'(zod), 32'd1);
    at(12); chk("s4 c12 zod", 32'(zod), 32'd0);
    at(16);

    tile(10'h20, 10'h80, 10'd9, 8'd1, 10'd0, 1'b0);
    at(7);
    rst = 1'b0;
    at(8);
    chk("s5 rst busy", 32'(busy), 32'd0);
    chk("s5 rst en_i", 32'(en_i), 32'd0);
    chk("s5 rst ird", 32'(ifmap_rd_en), 32'd0);
    rst = 1'b1;
    at(25);
    tile(10'h20, 10'h80, 10'd9, 8'd1, 10'd0, 1'b0);
    at(15); chk("s5 done", 32'(done), 32'd1);
    at(16);

    tile(10'h30, 10'h90, 10'd5, 8'd0, 10'd2, 1'b1);
    at(15); chk("s6 c15 done", 32'(done), 32'd1);
    at(16); chk("s6 c16 busy", 32'(busy), 32'd0);
    at(17); chk("s6 c17 busy", 32'(busy), 32'd1);
    start = 1'b0;
    at(31); chk("s6 2nd done", 32'(done), 32'd1);
    at(33);

    for (int t = 0; t < 40; t++) begin
      rnd_params();
      start = 1'b1;
      for (int c = 0; c < 22; c++) begin
        @(posedge clk);
        #1;
        start = ($urandom % 8 == 0);
        if ($urandom % 4 == 0) rnd_params();
        rst = ($urandom % 60 != 0);
      end
      start = 1'b0;
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onedconv_feed_ctrl.md
Name: onedconv_feed_ctrl

Overview:
Sequencing controller placed directly upstream of the 1-D convolution input buffers. For each tile it reads weights and ifmap samples from BRAM and generates the per-row shift enables and zero/data selects for the weight and ifmap shift registers, including zero padding. Data buses run straight from BRAM to the buffers; this block owns addresses, read enables, shift enables, zero selects and the start/busy/done handshake.

Parameters:
DW, 16, sample width; used only for documentation and checks.
Dimension, 16, number of shift-register rows (PE rows).
AW, 10, BRAM address width.
STRIDE, 1, ifmap offset in samples between adjacent rows.
Derived values:
- DEPTH = Dimension+1, the shift-register depth.
- N = (Dimension-1)*STRIDE + DEPTH, the ifmap words per tile.

Ports:
clk  in  1  clock; all logic on posedge. Outputs are stable for the buffers' negedge.
rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle tile request; sampled only in IDLE
weight_base  in  AW  first weight address; captured on start
ifmap_base  in  AW  address of real sample 0; captured on start
ifmap_len  in  AW  number of real ifmap samples; captured on start
pad_left  in  8  number of leading zero samples; captured on start
tile_start  in  AW  virtual index of this tile's sample k=0; captured on start
weight_addr  out  AW  weight BRAM address
weight_rd_en  out  1  weight BRAM read enable
ifmap_addr  out  AW  ifmap BRAM address
ifmap_rd_en  out  1  ifmap BRAM read enable
en_shift_reg_weight_muxed  out  Dimension  per-row weight shift enable
en_shift_reg_ifmap_muxed  out  Dimension  per-row ifmap shift enable
zero_or_data_weight  out  1  1 = pass weight data, 0 = inject zero
zero_or_data  out  1  1 = pass ifmap data, 0 = inject zero
busy  out  1  tile in progress
done  out  1  one-cycle pulse when a tile is fully loaded

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, all counters 0, every output 0. This applies mid-tile too; the partial tile is abandoned and no done is issued.
- States and transitions:
  - IDLE -> WLOAD on start.
  - WLOAD (j = 0..DEPTH-1) -> ILOAD.
  - ILOAD (k = 0..N-1) -> FLUSH.
  - FLUSH (1 cycle) -> DONE.
  - DONE (1 cycle) -> IDLE.
- start while not in IDLE is ignored. The captured inputs do not change during a tile.
- Address stage (combinational from state and counters, registered out):
  - WLOAD, j=0: weight_rd_en=0 (zero slot).
  - WLOAD, j>=1: weight_rd_en=1, weight_addr = weight_base + j - 1 (mod 2^AW).
  - ILOAD: virtual index v = tile_start + k. The sample is valid iff pad_left <= v < pad_left + ifmap_len, compared at AW+9 bits with no wrap.
  - ILOAD, valid sample: ifmap_rd_en=1, ifmap_addr = ifmap_base + v - pad_left.
  - ILOAD, invalid sample: ifmap_rd_en=0, ifmap_addr = ifmap_base.
- Alignment stage: BRAM read latency is 1 cycle, so the shift controls for a word are asserted exactly one cycle after its address. FLUSH exists to emit the controls for the last ifmap word.
- Weight controls (one cycle after WLOAD slot j):
  - en_shift_reg_weight_muxed = all ones.
  - zero_or_data_weight = (j != 0).
- Ifmap controls (one cycle after ILOAD slot k):
  - Row i enable = 1 iff i*STRIDE <= k < i*STRIDE + DEPTH.
  - zero_or_data = valid(k).
- All enables are 0 in every other cycle, and both zero flags are 0 when idle.
- Timeline with start accepted at edge 0:
  - WLOAD occupies cycles 1..DEPTH.
  - ILOAD occupies cycles DEPTH+1..DEPTH+N.
  - FLUSH is cycle DEPTH+N+1.
  - busy=1 over cycles 1..DEPTH+N+1.
  - done=1 and busy=0 at cycle DEPTH+N+2.
- start may be asserted in the done cycle: DONE ignores it; it is accepted on the next cycle in IDLE.
- ifmap_len=0 produces an all-zero tile. The enable pattern is unchanged; zero_or_data stays 0.

Optional Feature:
ONEDCONV_FEED_PERF_EN:
- Defined: adds outputs tile_count[31:0] (completed tiles, incremented at done) and pad_count[31:0] (ILOAD slots with zero_or_data=0). Both clear on reset and saturate at all ones.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
Bench parameters for all scenarios: Dimension=4, STRIDE=1, so DEPTH=5 and N=8.
1. Reset, then idle 5 cycles -> all outputs 0, busy=0.
2. start, weight_base=0x10, ifmap_base=0x40, ifmap_len=20, pad_left=0, tile_start=0 -> weight addrs 0x10..0x13 at cycles 2..5 (zero slot at cycle 1), ifmap addrs 0x40..0x47 at cycles 6..13, done pulse at cycle 15.
3. Same as 2, checking the ifmap enable rows at cycles 7..14 -> row0=1 at cycles 7..11, row3=1 at cycles 10..14; zero_or_data_weight=0 only at cycle 2.
4. pad_left=2, tile_start=0, ifmap_len=3 -> zero_or_data=0 for k=0,1 and k=5..7, 1 for k=2..4; ifmap_rd_en=0 on invalid slots.
5. Reset pulse at cycle 8 of a tile -> next cycle all outputs 0, no done; a following start runs a full tile normally.
6. start held high through the whole tile -> done at cycle 15 with no mid-tile restart; the next tile's busy rises at cycle 17.
